// File: rtl/aib_rx_align_pkg.sv
// Shared types and constants for the AIB receive frame aligner.
// Marker pairs are encoded as {data1, data0} of the marker lane.
package aib_rx_align_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    localparam logic [1:0] MARKER_HEAD = 2'b01;
    localparam logic [1:0] MARKER_BODY = 2'b10;

    // A programmed count of zero behaves like one.
    function automatic logic [4:0] cnt_target(input logic [3:0] c);
        return (c == 4'd0) ? 5'd1 : {1'b0, c};
    endfunction

endpackage

// File: rtl/aib_rx_frame_align_if.sv
// Data path bundle of the aligner: DDR sample pairs in, assembled frame words out.
// o_valid qualifies o_word for exactly one cycle; there is no backpressure (no ready).
interface aib_rx_frame_align_if #(
    parameter int NumIo      = 96,
    parameter int FrameBeats = 2
);
    logic [NumIo-1:0]              i_rx_data0;
    logic [NumIo-1:0]              i_rx_data1;
    logic [FrameBeats*2*NumIo-1:0] o_word;
    logic                          o_valid;

    modport master (output i_rx_data0, output i_rx_data1, input o_word, input o_valid);
    modport slave  (input i_rx_data0, input i_rx_data1, output o_word, output o_valid);
endinterface

// File: rtl/aib_rx_beat_pack.sv
// Interleaves the rising/falling samples of every IO into one beat and pulls out
// the marker lane pair as {data1, data0}.
module aib_rx_beat_pack #(
    parameter int NumIo    = 96,
    parameter int MarkerIo = NumIo - 1
) (
    input  logic [NumIo-1:0]   data0,
    input  logic [NumIo-1:0]   data1,
    output logic [2*NumIo-1:0] beat,
    output logic [1:0]         marker
);
    always_comb begin
        beat = '0;
        for (int i = 0; i < NumIo; i++) begin
            beat[2*i]   = data0[i];
            beat[2*i+1] = data1[i];
        end
        marker = {data1[MarkerIo], data0[MarkerIo]};
    end
endmodule

// File: rtl/aib_rx_frame_align.sv
// Frame aligner: hunts for the marker lane pattern, verifies it over several frames,
// then assembles FrameBeats beats per frame and tracks marker errors while locked.
module aib_rx_frame_align
    import aib_rx_align_pkg::*;
#(
    parameter int NumIo      = 96,
    parameter int FrameBeats = 2,
    parameter int MarkerIo   = NumIo - 1,
    parameter int ErrCntW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               c_enable,
    input  logic [3:0]         c_lock_cnt,
    input  logic [3:0]         c_unlock_cnt,
    input  logic               c_err_clr,
    aib_rx_frame_align_if.slave rx,
    output logic               o_locked,
    output logic [ErrCntW-1:0] o_err_cnt,
    output logic [1:0]         o_state
);
    localparam int BeatW = 2 * NumIo;
    localparam int WordW = FrameBeats * BeatW;
    localparam int PhW   = (FrameBeats > 1) ? $clog2(FrameBeats) : 1;

    logic [NumIo-1:0]   d0_q, d1_q;
    logic [BeatW-1:0]   beat;
    logic [1:0]         marker;
    align_state_e       state_q, state_d;
    logic [PhW-1:0]     phase_q, phase_d, phase_nxt;
    logic [3:0]         good_q, good_d, bad_q, bad_d;
    logic               frame_bad_q, frame_bad_d;
    logic [WordW-1:0]   asm_q, asm_d, word_q, word_d, frame_tmp;
    logic               valid_q, valid_d, locked_q, locked_d;
    logic [ErrCntW-1:0] err_q, err_d, err_inc;
    logic               mismatch, last_beat;

    aib_rx_beat_pack #(.NumIo(NumIo), .MarkerIo(MarkerIo)) u_pack (
        .data0  (d0_q),
        .data1  (d1_q),
        .beat   (beat),
        .marker (marker)
    );

    assign last_beat = (phase_q == PhW'(FrameBeats - 1));
    assign phase_nxt = last_beat ? '0 : phase_q + PhW'(1);
    assign mismatch  = (marker != ((phase_q == '0) ? MARKER_HEAD : MARKER_BODY));
    assign err_inc   = (err_q == '1) ? err_q : err_q + ErrCntW'(1);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        good_d      = good_q;
        bad_d       = bad_q;
        frame_bad_d = frame_bad_q;
        asm_d       = asm_q;
        word_d      = word_q;
        valid_d     = 1'b0;
        err_d       = err_q;
        frame_tmp   = asm_q;
        frame_tmp[int'(phase_q)*BeatW +: BeatW] = beat;

        if (!c_enable) begin
            state_d     = HUNT;
            phase_d     = '0;
            good_d      = '0;
            bad_d       = '0;
            frame_bad_d = 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    // Phase stays 0 in HUNT, so phase_nxt is the slot after a head beat.
                    if (marker == MARKER_HEAD) begin
                        state_d = VERIFY;
                        good_d  = '0;
                        phase_d = phase_nxt;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_d = HUNT;
                        phase_d = '0;
                        good_d  = '0;
                    end else begin
                        phase_d = phase_nxt;
                        if (last_beat) begin
                            if ({1'b0, good_q} + 5'd1 >= cnt_target(c_lock_cnt)) begin
                                state_d     = LOCKED;
                                good_d      = '0;
                                bad_d       = '0;
                                frame_bad_d = 1'b0;
                            end else begin
                                good_d = good_q + 4'd1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    phase_d = phase_nxt;
                    asm_d   = frame_tmp;
                    if (!last_beat) begin
                        frame_bad_d = frame_bad_q | mismatch;
                    end else begin
                        frame_bad_d = 1'b0;
                        if (!(frame_bad_q | mismatch)) begin
                            valid_d = 1'b1;
                            word_d  = frame_tmp;
                            bad_d   = '0;
                        end else begin
                            err_d = err_inc;
                            // The frame that exhausts the unlock budget is dropped, not emitted.
                            if ({1'b0, bad_q} + 5'd1 >= cnt_target(c_unlock_cnt)) begin
                                state_d = HUNT;
                                phase_d = '0;
                                bad_d   = '0;
                            end else begin
                                bad_d   = bad_q + 4'd1;
                                valid_d = 1'b1;
                                word_d  = frame_tmp;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (c_err_clr) err_d = '0;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d0_q        <= '0;
            d1_q        <= '0;
            state_q     <= HUNT;
            phase_q     <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            frame_bad_q <= 1'b0;
            asm_q       <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            d0_q        <= rx.i_rx_data0;
            d1_q        <= rx.i_rx_data1;
            state_q     <= state_d;
            phase_q     <= phase_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            frame_bad_q <= frame_bad_d;
            asm_q       <= asm_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign rx.o_word  = word_q;
    assign rx.o_valid = valid_q;
    assign o_locked   = locked_q;
    assign o_err_cnt  = err_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_aib_rx_frame_align.sv
// Bench for aib_rx_frame_align: frame generator with an expected-word queue,
// a negedge monitor for o_valid/o_word/latency, and one task per scenario.
module tb_aib_rx_frame_align;
    import aib_rx_align_pkg::*;

    localparam int NumIo      = 96;
    localparam int FrameBeats = 2;
    localparam int MarkerIo   = NumIo - 1;
    localparam int ErrCntW    = 4;
    localparam int BeatW      = 2 * NumIo;
    localparam int WordW      = FrameBeats * BeatW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               c_enable = 1'b0;
    logic [3:0]         c_lock_cnt = 4'd3;
    logic [3:0]         c_unlock_cnt = 4'd2;
    logic               c_err_clr = 1'b0;
    logic               o_locked;
    logic [ErrCntW-1:0] o_err_cnt;
    logic [1:0]         o_state;

    aib_rx_frame_align_if #(.NumIo(NumIo), .FrameBeats(FrameBeats)) rx_if ();

    aib_rx_frame_align #(
        .NumIo(NumIo), .FrameBeats(FrameBeats), .MarkerIo(MarkerIo), .ErrCntW(ErrCntW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .c_enable     (c_enable),
        .c_lock_cnt   (c_lock_cnt),
        .c_unlock_cnt (c_unlock_cnt),
        .c_err_clr    (c_err_clr),
        .rx           (rx_if),
        .o_locked     (o_locked),
        .o_err_cnt    (o_err_cnt),
        .o_state      (o_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [WordW-1:0] exp_q[$];
    int               exp_cyc_q[$];
    logic [1:0]         st_h;
    logic               lk_h;
    logic [ErrCntW-1:0] err_h;

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every o_valid must match the oldest expected word at its expected cycle
    always @(negedge clk) begin
        if (rx_if.o_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid cyc=%0d word=%0h", cyc, rx_if.o_word);
            end else begin
                logic [WordW-1:0] w;
                int c;
                w = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                if (rx_if.o_word !== w) begin
                    failures++;
                    $display("FAIL word cyc=%0d got=%0h exp=%0h", cyc, rx_if.o_word, w);
                end
                checks++;
                if (cyc !== c) begin
                    failures++;
                    $display("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, c);
                end
            end
        end else if (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
            checks++;
            failures++;
            $display("FAIL missing_valid cyc=%0d exp_cyc=%0d", cyc, exp_cyc_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
    end

    task automatic drive_beat(input logic [NumIo-1:0] d0, input logic [NumIo-1:0] d1);
        rx_if.i_rx_data0 = d0;
        rx_if.i_rx_data1 = d1;
        @(posedge clk);
        #1;
    endtask

    // bad_phase < 0 sends a clean frame; otherwise that beat's marker becomes (1,1).
    // Status after the previous frame is captured once the head beat has gone in.
    task automatic send_frame(input int bad_phase, input bit push, input bit clr_head);
        logic [WordW-1:0] w;
        logic [NumIo-1:0] d0, d1;
        w = '0;
        for (int p = 0; p < FrameBeats; p++) begin
            for (int i = 0; i < NumIo; i++) begin
                d0[i] = 1'($urandom_range(0, 1));
                d1[i] = 1'($urandom_range(0, 1));
            end
            if (p == bad_phase) begin
                d0[MarkerIo] = 1'b1; d1[MarkerIo] = 1'b1;
            end else if (p == 0) begin
                d0[MarkerIo] = 1'b1; d1[MarkerIo] = 1'b0;
            end else begin
                d0[MarkerIo] = 1'b0; d1[MarkerIo] = 1'b1;
            end
            for (int i = 0; i < NumIo; i++) begin
                w[p*BeatW + 2*i]     = d0[i];
                w[p*BeatW + 2*i + 1] = d1[i];
            end
            if (p == FrameBeats - 1 && push) begin
                exp_q.push_back(w);
                exp_cyc_q.push_back(cyc + 2);
            end
            c_err_clr = (p == 0) && clr_head;
            drive_beat(d0, d1);
            c_err_clr = 1'b0;
            if (p == 0) begin
                st_h  = o_state;
                lk_h  = o_locked;
                err_h = o_err_cnt;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        c_enable = 1'b1;
        c_lock_cnt = 4'd3;
        c_unlock_cnt = 4'd2;
        repeat (3) drive_beat('0, '0);
        checks += 5;
        if (rx_if.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rx_if.o_valid); end
        if (rx_if.o_word !== '0) begin failures++; $display("FAIL reset_word got=%0h exp=0", rx_if.o_word); end
        if (o_locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", o_locked); end
        if (o_err_cnt !== '0) begin failures++; $display("FAIL reset_err got=%0d exp=0", o_err_cnt); end
        if (o_state !== 2'(HUNT)) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        rst = 1'b0;
    endtask

    task automatic test_lock_clean();
        send_frame(-1, 0, 0);
        send_frame(-1, 0, 0);
        checks += 2;
        if (st_h !== 2'(VERIFY)) begin failures++; $display("FAIL lock_verify_state got=%0d exp=1", st_h); end
        if (lk_h !== 1'b0) begin failures++; $display("FAIL lock_early got=%0b exp=0", lk_h); end
        send_frame(-1, 0, 0);
        send_frame(-1, 1, 0);
        checks += 2;
        if (st_h !== 2'(LOCKED)) begin failures++; $display("FAIL lock_state got=%0d exp=2", st_h); end
        if (lk_h !== 1'b1) begin failures++; $display("FAIL lock_locked got=%0b exp=1", lk_h); end
        send_frame(-1, 1, 0);
    endtask

    task automatic test_single_error();
        send_frame(1, 1, 0);
        send_frame(-1, 1, 0);
        checks += 2;
        if (err_h !== 4'd1) begin failures++; $display("FAIL single_err got=%0d exp=1", err_h); end
        if (lk_h !== 1'b1) begin failures++; $display("FAIL single_lock got=%0b exp=1", lk_h); end
        send_frame(1, 1, 0);
        send_frame(-1, 1, 0);
        checks += 2;
        if (err_h !== 4'd2) begin failures++; $display("FAIL badcnt_reset_err got=%0d exp=2", err_h); end
        if (lk_h !== 1'b1) begin failures++; $display("FAIL badcnt_reset_lock got=%0b exp=1", lk_h); end
    endtask

    task automatic test_unlock();
        send_frame(0, 1, 0);
        send_frame(1, 0, 0);
        checks += 2;
        send_frame(-1, 0, 0);
        if (st_h !== 2'(HUNT)) begin failures++; $display("FAIL unlock_state got=%0d exp=0", st_h); end
        if (err_h !== 4'd4) begin failures++; $display("FAIL unlock_err got=%0d exp=4", err_h); end
        send_frame(-1, 0, 0);
        send_frame(-1, 0, 0);
        send_frame(-1, 1, 0);
        checks++;
        if (st_h !== 2'(LOCKED)) begin failures++; $display("FAIL relock_state got=%0d exp=2", st_h); end
        send_frame(-1, 1, 0);
    endtask

    task automatic test_enable_drop();
        send_frame(1, 1, 0);
        send_frame(-1, 1, 0);
        checks++;
        if (err_h !== 4'd5) begin failures++; $display("FAIL en_pre_err got=%0d exp=5", err_h); end
        drive_beat('0, '0);
        c_enable = 1'b0;
        drive_beat('0, '0);
        drive_beat('0, '0);
        checks += 4;
        if (o_locked !== 1'b0) begin failures++; $display("FAIL en_locked got=%0b exp=0", o_locked); end
        if (o_state !== 2'(HUNT)) begin failures++; $display("FAIL en_state got=%0d exp=0", o_state); end
        if (o_err_cnt !== 4'd5) begin failures++; $display("FAIL en_err_hold got=%0d exp=5", o_err_cnt); end
        if (rx_if.o_valid !== 1'b0) begin failures++; $display("FAIL en_valid got=%0b exp=0", rx_if.o_valid); end
        c_enable = 1'b1;
    endtask

    task automatic test_verify_error();
        c_lock_cnt = 4'd3;
        send_frame(-1, 0, 0);
        send_frame(-1, 0, 0);
        send_frame(1, 0, 0);
        send_frame(-1, 0, 0);
        checks++;
        if (st_h !== 2'(HUNT)) begin failures++; $display("FAIL verr_state got=%0d exp=0", st_h); end
        send_frame(-1, 0, 0);
        send_frame(-1, 0, 0);
        checks++;
        if (st_h !== 2'(VERIFY)) begin failures++; $display("FAIL verr_restart got=%0d exp=1", st_h); end
        send_frame(-1, 1, 0);
        checks++;
        if (st_h !== 2'(LOCKED)) begin failures++; $display("FAIL verr_relock got=%0d exp=2", st_h); end
    endtask

    task automatic test_err_sat();
        for (int k = 0; k < 16; k++) begin
            send_frame(1, 1, 0);
            send_frame(-1, 1, 0);
        end
        checks += 2;
        if (err_h !== 4'd15) begin failures++; $display("FAIL err_sat got=%0d exp=15", err_h); end
        if (lk_h !== 1'b1) begin failures++; $display("FAIL err_sat_lock got=%0b exp=1", lk_h); end
        send_frame(1, 1, 0);
        send_frame(-1, 1, 1);
        checks++;
        if (err_h !== 4'd0) begin failures++; $display("FAIL err_clr_wins got=%0d exp=0", err_h); end
        send_frame(1, 1, 0);
        send_frame(-1, 1, 0);
        checks++;
        if (err_h !== 4'd1) begin failures++; $display("FAIL err_after_clr got=%0d exp=1", err_h); end
    endtask

    task automatic test_reset_mid_frame();
        logic [NumIo-1:0] d0, d1;
        d0 = '0; d1 = '0;
        d0[MarkerIo] = 1'b1;
        d0[3] = 1'b1;
        drive_beat(d0, d1);
        rst = 1'b1;
        drive_beat('0, '0);
        drive_beat('0, '0);
        rst = 1'b0;
        checks += 4;
        if (o_locked !== 1'b0) begin failures++; $display("FAIL rst_mid_locked got=%0b exp=0", o_locked); end
        if (o_state !== 2'(HUNT)) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", o_state); end
        if (o_err_cnt !== '0) begin failures++; $display("FAIL rst_mid_err got=%0d exp=0", o_err_cnt); end
        if (rx_if.o_word !== '0) begin failures++; $display("FAIL rst_mid_word got=%0h exp=0", rx_if.o_word); end
    endtask

    task automatic test_mid_frame_start();
        logic [NumIo-1:0] d0, d1;
        d0 = '0; d1 = '0;
        d1[MarkerIo] = 1'b1;
        c_lock_cnt = 4'd0;
        drive_beat(d0, d1);
        send_frame(-1, 0, 0);
        checks++;
        if (st_h !== 2'(HUNT)) begin failures++; $display("FAIL midstart_state got=%0d exp=0", st_h); end
        send_frame(-1, 1, 0);
        checks++;
        if (st_h !== 2'(LOCKED)) begin failures++; $display("FAIL lock0_state got=%0d exp=2", st_h); end
        send_frame(-1, 1, 0);
        send_frame(-1, 1, 0);
    endtask

    task automatic test_drain();
        drive_beat('0, '0);
        c_enable = 1'b0;
        repeat (4) drive_beat('0, '0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_pending got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        rx_if.i_rx_data0 = '0;
        rx_if.i_rx_data1 = '0;
        #1;
        test_reset();
        test_lock_clean();
        test_single_error();
        test_unlock();
        test_enable_drop();
        test_verify_error();
        test_err_sat();
        test_reset_mid_frame();
        test_mid_frame_start();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
